// File: rtl/sdm_pkg.sv
// Shared constants and elaboration-time helpers for the sigma-delta DAC input stage.
//   SDM_DATA_W    : default sample / adder operand width
//   sdm_midscale  : 1 followed by width-1 zeros (idle DAC code)
//   sdm_cnt_w     : OSR counter width
//   sdm_lvl_w     : FIFO occupancy width (must hold the value FIFO_DEPTH)
package sdm_pkg;

  localparam int unsigned SDM_DATA_W = 4;

  function automatic logic [31:0] sdm_midscale(input int unsigned width);
    return 32'(1) << (width - 1);
  endfunction

  function automatic int unsigned sdm_cnt_w(input int unsigned osr);
    return $clog2(osr);
  endfunction

  function automatic int unsigned sdm_lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdm_sample_feeder_if.sv
// PCM sample stream handshake into the sample feeder.
//   s_data  : unsigned sample
//   s_valid : s_data is valid
//   s_ready : receiver can accept this cycle
// master drives data/valid, slave drives ready.
interface sdm_sample_feeder_if
  import sdm_pkg::*;
#(
  parameter int unsigned DATA_W = SDM_DATA_W
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/sdm_sample_feeder_sync_fifo.sv
// Small synchronous FIFO with registered occupancy and no write-to-read bypass.
//   push/wdata : write request; ignored when full
//   pop/rdata  : read request; rdata is the current head (valid when !empty)
//   full/empty : derived from the registered level
//   level      : current occupancy, 0..FIFO_DEPTH
module sdm_sync_fifo
  import sdm_pkg::*;
#(
  parameter int unsigned DATA_W     = SDM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic                                pop,
  input  logic [DATA_W-1:0]                   wdata,
  output logic [DATA_W-1:0]                   rdata,
  output logic                                full,
  output logic                                empty,
  output logic [sdm_lvl_w(FIFO_DEPTH)-1:0]    level
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = sdm_lvl_w(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LvlW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Guards live here too so the FIFO is safe on its own.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Depth is a power of two, so pointers wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (do_push && !do_pop)      level_d = level_q + LvlW'(1);
    else if (do_pop && !do_push) level_d = level_q - LvlW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only read while level is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sdm_sample_feeder.sv
// Input stage feeding the adder `a` operand of the sigma-delta DAC.
// Buffers PCM samples in a FIFO and presents one sample on dac_a for OSR enabled clocks.
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_if         : sample stream (slave side)
//   enable       : gates the OSR counter and FIFO pops
//   dac_a        : registered sample to the adder, midscale after reset
//   sample_tick  : one-cycle pulse after each tick edge
//   underrun     : sticky, set when a tick finds the FIFO empty
//   underrun_clr : synchronous clear; a same-cycle set wins
//   fifo_level   : FIFO occupancy
module sdm_sample_feeder
  import sdm_pkg::*;
#(
  parameter int unsigned DATA_W     = SDM_DATA_W,
  parameter int unsigned OSR        = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  sdm_sample_feeder_if.slave               s_if,
  input  logic                             enable,
  output logic [DATA_W-1:0]                dac_a,
  output logic                             sample_tick,
  output logic                             underrun,
  input  logic                             underrun_clr,
  output logic [sdm_lvl_w(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int unsigned       CntW     = sdm_cnt_w(OSR);
  localparam logic [CntW-1:0]   CntMax   = CntW'(OSR - 1);
  localparam logic [DATA_W-1:0] Midscale = DATA_W'(sdm_midscale(DATA_W));

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] dac_a_q, dac_a_d;
  logic              tick_q;
  logic              underrun_q, underrun_d;
  logic              tick, pop, push;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Ready comes from the registered level only; a same-cycle pop never frees a slot.
  assign s_if.s_ready = !fifo_full;
  assign push         = s_if.s_valid && !fifo_full;
  assign tick         = enable && (cnt_q == CntMax);
  assign pop          = tick && !fifo_empty;

  sdm_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (s_if.s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    cnt_d      = cnt_q;
    dac_a_d    = dac_a_q;
    underrun_d = underrun_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + CntW'(1);
    if (pop)    dac_a_d = fifo_rdata;
    if (tick && fifo_empty) underrun_d = 1'b1;
    else if (underrun_clr)  underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dac_a_q    <= Midscale;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dac_a_q    <= dac_a_d;
      tick_q     <= tick;
      underrun_q <= underrun_d;
    end
  end

  assign dac_a       = dac_a_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_sdm_sample_feeder.sv
// Directed bench for sdm_sample_feeder with DATA_W=4, OSR=4, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sdm_sample_feeder;
  import sdm_pkg::*;

  localparam int unsigned DataW = 4;
  localparam int unsigned Osr   = 4;
  localparam int unsigned Depth = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             underrun_clr;
  logic [DataW-1:0] dac_a;
  logic             sample_tick;
  logic             underrun;
  logic [2:0]       fifo_level;

  int n_checks;
  int n_pass;

  sdm_sample_feeder_if #(.DATA_W(DataW)) s_if ();

  sdm_sample_feeder #(
    .DATA_W     (DataW),
    .OSR        (Osr),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (s_if),
    .enable       (enable),
    .dac_a        (dac_a),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    enable         = 1'b0;
    underrun_clr   = 1'b0;
    s_if.s_valid   = 1'b0;
    s_if.s_data    = '0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Pushes samples back-to-back with enable low; s_valid drops afterwards.
  task automatic push_samples(input logic [DataW-1:0] d0, input logic [DataW-1:0] d1,
                              input logic [DataW-1:0] d2, input int n);
    logic [DataW-1:0] vals [3];
    vals[0] = d0;
    vals[1] = d1;
    vals[2] = d2;
    for (int i = 0; i < n; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = vals[i];
      step(1);
    end
    s_if.s_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // 1. Reset values
    do_reset();
    check_eq("rst dac_a", 32'(dac_a), 32'h8);
    check_eq("rst s_ready", 32'(s_if.s_ready), 32'd1);
    check_eq("rst level", 32'(fifo_level), 32'd0);
    check_eq("rst underrun", 32'(underrun), 32'd0);
    check_eq("rst tick", 32'(sample_tick), 32'd0);

    // 2. Normal stream: 3, A, 5 each held for 4 cycles
    push_samples(4'h3, 4'hA, 4'h5, 3);
    check_eq("t2 level", 32'(fifo_level), 32'd3);
    enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [DataW-1:0] exp_dac;
      step(1);
      exp_dac = (i < 4) ? 4'h8 : (i < 8) ? 4'h3 : (i < 12) ? 4'hA : 4'h5;
      check_eq($sformatf("t2 dac c%0d", i), 32'(dac_a), 32'(exp_dac));
      check_eq($sformatf("t2 tick c%0d", i), 32'(sample_tick), 32'((i % 4) == 0));
    end
    check_eq("t2 level end", 32'(fifo_level), 32'd0);
    enable = 1'b0;

    // 1b. Asynchronous reset mid-run with 3 samples buffered
    push_samples(4'h1, 4'h2, 4'h3, 3);
    check_eq("t1 level pre", 32'(fifo_level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1 async level", 32'(fifo_level), 32'd0);
    check_eq("t1 async dac", 32'(dac_a), 32'h8);
    check_eq("t1 async ready", 32'(s_if.s_ready), 32'd1);
    step(1);
    rst_n = 1'b1;

    // 3. Full handling
    do_reset();
    s_if.s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_if.s_data = 4'(i);
      step(1);
      check_eq($sformatf("t3 level p%0d", i), 32'(fifo_level), 32'(i));
    end
    check_eq("t3 ready full", 32'(s_if.s_ready), 32'd0);
    s_if.s_data = 4'h9;
    step(2);
    check_eq("t3 level refused", 32'(fifo_level), 32'd4);
    enable = 1'b1;
    step(3);
    check_eq("t3 level pre-pop", 32'(fifo_level), 32'd4);
    step(1);
    check_eq("t3 dac pop1", 32'(dac_a), 32'h1);
    check_eq("t3 level pop1", 32'(fifo_level), 32'd3);
    check_eq("t3 ready pop1", 32'(s_if.s_ready), 32'd1);
    step(1);
    check_eq("t3 level accept", 32'(fifo_level), 32'd4);
    check_eq("t3 ready accept", 32'(s_if.s_ready), 32'd0);
    s_if.s_valid = 1'b0;
    step(15);
    check_eq("t3 dac last", 32'(dac_a), 32'h9);
    check_eq("t3 level last", 32'(fifo_level), 32'd0);
    enable = 1'b0;

    // 4. Underrun, set wins over clear, later clear
    do_reset();
    push_samples(4'h7, 4'h0, 4'h0, 1);
    enable = 1'b1;
    step(4);
    check_eq("t4 dac first", 32'(dac_a), 32'h7);
    check_eq("t4 underrun first", 32'(underrun), 32'd0);
    step(3);
    check_eq("t4 underrun pre", 32'(underrun), 32'd0);
    step(1);
    check_eq("t4 dac hold", 32'(dac_a), 32'h7);
    check_eq("t4 underrun set", 32'(underrun), 32'd1);
    check_eq("t4 tick empty", 32'(sample_tick), 32'd1);
    step(3);
    underrun_clr = 1'b1;
    step(1);
    check_eq("t4 set wins", 32'(underrun), 32'd1);
    underrun_clr = 1'b0;
    step(1);
    underrun_clr = 1'b1;
    step(1);
    check_eq("t4 clear", 32'(underrun), 32'd0);
    underrun_clr = 1'b0;
    enable = 1'b0;

    // 5. Enable pause at counter==2, push while paused
    do_reset();
    push_samples(4'h6, 4'h0, 4'h0, 1);
    enable = 1'b1;
    step(4);
    check_eq("t5 dac first", 32'(dac_a), 32'h6);
    step(2);
    enable       = 1'b0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 4'hB;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == 0) s_if.s_valid = 1'b0;
      check_eq($sformatf("t5 pause tick c%0d", i), 32'(sample_tick), 32'd0);
      check_eq($sformatf("t5 pause dac c%0d", i), 32'(dac_a), 32'h6);
    end
    check_eq("t5 level paused", 32'(fifo_level), 32'd1);
    enable = 1'b1;
    step(1);
    check_eq("t5 resume tick1", 32'(sample_tick), 32'd0);
    check_eq("t5 resume dac1", 32'(dac_a), 32'h6);
    step(1);
    check_eq("t5 resume tick2", 32'(sample_tick), 32'd1);
    check_eq("t5 resume dac2", 32'(dac_a), 32'hB);
    check_eq("t5 no underrun", 32'(underrun), 32'd0);
    enable = 1'b0;

    // 6. Push and pop on the same tick edge at level 2
    do_reset();
    push_samples(4'h1, 4'h2, 4'h0, 2);
    enable = 1'b1;
    step(3);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 4'hC;
    step(1);
    check_eq("t6 level same", 32'(fifo_level), 32'd2);
    check_eq("t6 dac head", 32'(dac_a), 32'h1);
    s_if.s_valid = 1'b0;
    step(4);
    check_eq("t6 dac second", 32'(dac_a), 32'h2);
    step(4);
    check_eq("t6 dac pushed", 32'(dac_a), 32'hC);
    check_eq("t6 level end", 32'(fifo_level), 32'd0);
    enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdm_sample_feeder.md
Name: sdm_sample_feeder

Overview:
Input stage directly upstream of the registered 4-bit ripple adder in the sigma-delta DAC datapath.
- Accepts PCM samples over a valid/ready handshake and buffers them in a small synchronous FIFO.
- Holds each sample on the adder's `a` operand for exactly OSR enabled clocks, then loads the next one.
- Flags underrun when a new sample is due but the FIFO is empty.

Parameters:
- DATA_W, 4: sample width; must match the adder operand width.
- OSR, 16: oversampling ratio, in enabled clocks per sample; legal range is 2 or more.
- FIFO_DEPTH, 4: buffer entries; must be a power of two, 2 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  incoming unsigned sample.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept; high whenever the FIFO is not full.
- enable  in  1  modulator run enable; gates the OSR counter and FIFO pops.
- dac_a  out  DATA_W  registered sample driven to the adder `a` input.
- sample_tick  out  1  registered one-cycle pulse when dac_a is updated by a tick.
- underrun  out  1  sticky flag: a tick occurred with the FIFO empty.
- underrun_clr  in  1  synchronous clear of underrun.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (asynchronous assert; synchronous release assumed upstream):
- FIFO empty, fifo_level=0, s_ready=1.
- OSR counter=0.
- dac_a=midscale, i.e. 1 followed by DATA_W-1 zeros (4'b1000).
- sample_tick=0, underrun=0.

Push:
- A handshake occurs at a clock edge where s_valid && s_ready.
- s_ready is derived from the registered level only (!full), not from the same-cycle pop.
- When full, a push is refused even if a pop occurs that cycle.
- A sample pushed at edge N is poppable no earlier than edge N+1; there is no bypass path.

OSR counter:
- While enable=1, counts 0..OSR-1 and wraps to 0.
- While enable=0, holds its value; no pops and no ticks occur.
- Pushes continue regardless of enable.

Tick:
- A tick is the edge where enable=1 and counter==OSR-1.
- On a tick with the FIFO non-empty: pop the head into dac_a and set sample_tick=1 for the following cycle.
- On a tick with the FIFO empty: dac_a holds its previous value, underrun is set, and sample_tick is still pulsed.

Per-sample latency:
- The first tick after enable rises is OSR enabled clocks later.
- A sample therefore appears on dac_a one cycle after its tick edge and is stable for exactly OSR enabled cycles.

Underrun flag:
- underrun_clr clears the flag.
- If a set and a clear occur in the same cycle, set wins.

fifo_level:
- +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.

Internal invariants:
- Pointers wrap modulo FIFO_DEPTH.
- No overflow is possible because pushes are refused when full.

enable deassert mid-period:
- The counter freezes and resumes from the same value.
- dac_a is unchanged while frozen.

Reset mid-operation:
- All state returns to reset values immediately; buffered samples are discarded.

Decomposition:
- Package `sdm_pkg`:
  - constant SDM_DATA_W = 4;
  - function `sdm_midscale(width)` returning 1 followed by width-1 zeros;
  - localparam helpers for the counter width ($clog2(OSR)) and the level width.
- Sub-module `sdm_sync_fifo`:
  - parameterised by DATA_W and FIFO_DEPTH;
  - ports: push, pop, wdata, rdata, full, empty, level.
  - The feeder top holds the OSR counter, the dac_a register, the tick and underrun logic.

Test Plan:
All scenarios use DATA_W=4, OSR=4, FIFO_DEPTH=4.
1. Reset check: hold rst_n=0, then release -> dac_a=4'h8, s_ready=1, fifo_level=0, underrun=0. Assert rst_n mid-run with 3 samples buffered -> fifo_level=0 and dac_a=4'h8 in the same cycle.
2. Normal stream: push 4'h3, 4'hA, 4'h5 back-to-back, then enable=1 -> dac_a=3 after the 1st tick (4 clocks), A after the 2nd, 5 after the 3rd; sample_tick pulses every 4th cycle; each value held for exactly 4 cycles.
3. Full handling: push 5 samples with no enable -> s_ready=0 after the 4th, 5th sample not accepted, fifo_level=4. Hold s_valid while enabling -> the sample is accepted the cycle after the first pop.
4. Underrun: push 1 sample (4'h7), enable -> dac_a=7. At the next tick dac_a stays 7 and underrun=1. Pulse underrun_clr on a later tick edge with the FIFO still empty -> underrun remains 1 (set wins).
5. Enable pause: disable at counter==2 for 10 cycles -> no tick, dac_a and counter unchanged. Re-enable -> tick occurs exactly 2 cycles later.
6. Simultaneous push and pop at fifo_level=2 on a tick edge -> fifo_level stays 2 and dac_a takes the old head.
